spi_regfile_slave: RTL

//   Parametrised SPI register-file peripheral: next generation of the write-only SPI config slave.

---
 rtl/spi_regfile_slave_if.sv | 27 ++
 rtl/spi_regfile_slave.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_slave_if.sv
// ---------------------------------------------------------------------------
// spi_regfile_slave_if
//   Chip-level SPI pin bundle between an SPI controller and the register-file
//   peripheral.
//   spi_sclk     controller -> peripheral  SPI clock (asynchronous to clk)
//   spi_copi     controller -> peripheral  controller-out data
//   spi_cs       controller -> peripheral  chip select, active-low
//   spi_cipo     peripheral -> controller  peripheral-out data
//   spi_cipo_oe  peripheral -> controller  cipo pad output-enable
// ---------------------------------------------------------------------------
interface spi_regfile_slave_if;
  logic spi_sclk;
  logic spi_copi;
  logic spi_cs;
  logic spi_cipo;
  logic spi_cipo_oe;

  modport master (
    output spi_sclk, spi_copi, spi_cs,
    input  spi_cipo, spi_cipo_oe
  );

  modport slave (
    input  spi_sclk, spi_copi, spi_cs,
    output spi_cipo, spi_cipo_oe
  );
endinterface

// File: rtl/spi_regfile_slave.sv
// ---------------------------------------------------------------------------
// spi_regfile_slave
//   SPI (CPHA=0, selectable CPOL) register-file peripheral. Frames are
//   [RW][ADDR][DATA], MSB first; RW=1 writes a register, RW=0 returns the
//   register on cipo during the DATA bits. Malformed frame lengths are
//   flagged and counted.
//   clk, rst     system clock (>= 8x sclk), asynchronous active-high reset
//   spi          SPI pins (slave modport)
//   regs_flat    register r at [r*DATA_W +: DATA_W]
//   wr_strobe    one-clk pulse per register write, wr_addr valid with it
//   frame_err    one-clk pulse after cs rises on a short/overlong frame
//   err_count    saturating frame error count
// ---------------------------------------------------------------------------
module spi_regfile_slave #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 5,
  parameter bit          CPOL     = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_regfile_slave_if.slave         spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err,
  output logic [7:0]                 err_count
);

  localparam int unsigned FLEN  = 1 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W = $clog2(FLEN + 2);
  localparam logic [CNT_W-1:0] FLEN_C     = CNT_W'(FLEN);
  localparam logic [CNT_W-1:0] LAST_C     = CNT_W'(FLEN - 1);
  localparam logic [CNT_W-1:0] SAT_C      = CNT_W'(FLEN + 1);
  localparam logic [CNT_W-1:0] ADDR_END_C = CNT_W'(ADDR_W);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, DONE} state_t;

  state_t              state, state_d;
  logic [2:0]          sclk_sr, cs_sr;
  logic [1:0]          copi_sr;
  logic [CNT_W-1:0]    bit_cnt, cnt_eff_c;
  logic [FLEN-1:0]     rx;
  logic                commit_pend;
  logic [DATA_W-1:0]   tx, tx_d, rd_word_c;
  logic                tx_loaded, ld_d;
  logic                cipo_q, cipo_d, oe_q;
  logic                rise_c, fall_c, lead_c, trail_c;
  logic                cs_now, in_frame_c, cs_rise_c;
  logic                sample_c, overrun_c, err_c, cm_hit_c;
  logic [ADDR_W-1:0]   cm_addr_c, rd_addr_c;

  // Two-flop synchronisers plus one history stage for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sr <= {3{CPOL}};
      cs_sr   <= 3'b111;
      copi_sr <= 2'b00;
    end else begin
      sclk_sr <= {sclk_sr[1:0], spi.spi_sclk};
      cs_sr   <= {cs_sr[1:0], spi.spi_cs};
      copi_sr <= {copi_sr[0], spi.spi_copi};
    end
  end

  assign rise_c     = sclk_sr[1] & ~sclk_sr[2];
  assign fall_c     = ~sclk_sr[1] & sclk_sr[2];
  assign lead_c     = CPOL ? fall_c : rise_c;
  assign trail_c    = CPOL ? rise_c : fall_c;
  assign cs_now     = cs_sr[1];
  // Frame is live while the previous synced cs was low, so a sample that
  // coincides with the cs rise still counts.
  assign in_frame_c = ~cs_sr[2];
  assign cs_rise_c  = cs_sr[1] & ~cs_sr[2];

  assign sample_c  = lead_c & in_frame_c & (bit_cnt < FLEN_C);
  assign overrun_c = lead_c & in_frame_c & (bit_cnt == FLEN_C);
  assign cnt_eff_c = bit_cnt + CNT_W'(sample_c);
  assign err_c     = cs_rise_c & (cnt_eff_c != '0) & (cnt_eff_c != FLEN_C);

  assign cm_addr_c = rx[DATA_W +: ADDR_W];
  assign cm_hit_c  = commit_pend & (32'(cm_addr_c) < NUM_REGS);
  assign rd_addr_c = rx[ADDR_W-1:0];

  // Read word selected by the address just shifted in; unmapped reads return 0
  always_comb begin
    rd_word_c = '0;
    if (32'(rd_addr_c) < NUM_REGS)
      rd_word_c = regs_flat[32'(rd_addr_c)*DATA_W +: DATA_W];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state and tx shifter control
  always_comb begin
    state_d = state;
    tx_d    = tx;
    ld_d    = tx_loaded;
    cipo_d  = 1'b0;
    if (cs_now) begin
      state_d = IDLE;
      tx_d    = '0;
      ld_d    = 1'b0;
    end else begin
      case (state)
        IDLE:  state_d = ADDR;
        ADDR:  if (sample_c && bit_cnt == ADDR_END_C)
                 state_d = rx[ADDR_W-1] ? WDATA : RDATA;
        WDATA: if (sample_c && bit_cnt == LAST_C) state_d = DONE;
        RDATA: begin
          // First trailing edge loads the word, later ones shift it out
          if (trail_c) begin
            tx_d = tx_loaded ? (tx << 1) : rd_word_c;
            ld_d = 1'b1;
          end
          if (sample_c && bit_cnt == LAST_C) state_d = DONE;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    cipo_d = (state_d == RDATA) & tx_d[DATA_W-1];
  end

  // Shift/count datapath, register file, error tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt     <= '0;
      rx          <= '0;
      commit_pend <= 1'b0;
      regs_flat   <= '0;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      frame_err   <= 1'b0;
      err_count   <= '0;
      tx          <= '0;
      tx_loaded   <= 1'b0;
      cipo_q      <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      if (cs_now)         bit_cnt <= '0;
      else if (sample_c)  bit_cnt <= bit_cnt + 1'b1;
      else if (overrun_c) bit_cnt <= SAT_C;
      if (sample_c) rx <= {rx[FLEN-2:0], copi_sr[1]};
      // RW sits at rx[FLEN-2] just before the final sample shifts in
      commit_pend <= sample_c & (bit_cnt == LAST_C) & rx[FLEN-2];
      wr_strobe   <= cm_hit_c;
      if (cm_hit_c) begin
        regs_flat[32'(cm_addr_c)*DATA_W +: DATA_W] <= rx[DATA_W-1:0];
        wr_addr <= cm_addr_c;
      end
      frame_err <= err_c;
      if (err_c && err_count != 8'hFF) err_count <= err_count + 1'b1;
      tx        <= tx_d;
      tx_loaded <= ld_d;
      cipo_q    <= cipo_d;
      oe_q      <= ~cs_now;
    end
  end

  assign spi.spi_cipo    = cipo_q;
  assign spi.spi_cipo_oe = oe_q;

endmodule
